// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the packed RGB pixel layout used by
// the VGA controller and its counters.
package vga_timing_pkg;

  // Horizontal timing in pixel clocks, counted from the start of hsync
  localparam int unsigned H_SYNC_DEF      = 96;
  localparam int unsigned H_ACT_START_DEF = 144;
  localparam int unsigned H_ACT_END_DEF   = 784;
  localparam int unsigned H_TOTAL_DEF     = 800;

  // Vertical timing in lines, counted from the start of vsync
  localparam int unsigned V_SYNC_DEF      = 2;
  localparam int unsigned V_ACT_START_DEF = 35;
  localparam int unsigned V_ACT_END_DEF   = 515;
  localparam int unsigned V_TOTAL_DEF     = 525;

  // Counter and address widths; 10 bits covers 0..799 and 0..524
  localparam int unsigned CNT_W  = 10;
  localparam int unsigned ADDR_W = 10;

  // Pixel word: R in [23:16], G in [15:8], B in [7:0]
  localparam int unsigned CH_W  = 8;
  localparam int unsigned RGB_W = 3 * CH_W;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap-around counter for one scan axis. Counts 0..TOTAL-1 while enabled;
// wrap is high on the enabled cycle that returns the count to zero, so the
// horizontal wrap can directly enable the vertical counter.
module vga_axis_counter #(
  parameter int unsigned TOTAL = 800,
  parameter int unsigned W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  assign wrap = en && (count == LAST);

  // Advance on enable and fall back to zero after the last count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en) begin
      if (wrap) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator. Two axis counters produce the raster position; sync,
// blanking, addresses and gated colour are pure decodes of the counters and
// the incoming pixel word, so colour for an address appears in the same cycle.
module vga_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_ACT_START = H_ACT_START_DEF,
  parameter int unsigned H_ACT_END   = H_ACT_END_DEF,
  parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_ACT_START = V_ACT_START_DEF,
  parameter int unsigned V_ACT_END   = V_ACT_END_DEF,
  parameter int unsigned V_TOTAL     = V_TOTAL_DEF
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [RGB_W-1:0]  vga_data,
  output logic [ADDR_W-1:0] h_addr,
  output logic [ADDR_W-1:0] v_addr,
  output logic              hsync,
  output logic              vsync,
  output logic              valid,
  output logic [CH_W-1:0]   vga_r,
  output logic [CH_W-1:0]   vga_g,
  output logic [CH_W-1:0]   vga_b
);

  localparam logic [CNT_W-1:0] H_SYNC_C      = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_START_C = CNT_W'(H_ACT_START);
  localparam logic [CNT_W-1:0] H_ACT_END_C   = CNT_W'(H_ACT_END);
  localparam logic [CNT_W-1:0] V_SYNC_C      = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_START_C = CNT_W'(V_ACT_START);
  localparam logic [CNT_W-1:0] V_ACT_END_C   = CNT_W'(V_ACT_END);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             line_wrap;
  logic             frame_wrap_unused;
  logic             h_valid;
  logic             v_valid;
  rgb_t             pixel;

  vga_axis_counter #(
    .TOTAL (H_TOTAL),
    .W     (CNT_W)
  ) u_h_counter (
    .clk   (pclk),
    .reset (reset),
    .en    (1'b1),
    .count (h_cnt),
    .wrap  (line_wrap)
  );

  // The line counter advances once per horizontal wrap
  vga_axis_counter #(
    .TOTAL (V_TOTAL),
    .W     (CNT_W)
  ) u_v_counter (
    .clk   (pclk),
    .reset (reset),
    .en    (line_wrap),
    .count (v_cnt),
    .wrap  (frame_wrap_unused)
  );

  // Sync pulses sit at the start of each line/frame; with both counters at
  // zero in reset, both syncs read as asserted (low)
  assign hsync = (h_cnt >= H_SYNC_C);
  assign vsync = (v_cnt >= V_SYNC_C);

  assign h_valid = (h_cnt >= H_ACT_START_C) && (h_cnt < H_ACT_END_C);
  assign v_valid = (v_cnt >= V_ACT_START_C) && (v_cnt < V_ACT_END_C);
  assign valid   = h_valid && v_valid;

  assign h_addr = h_valid ? ADDR_W'(h_cnt - H_ACT_START_C) : '0;
  assign v_addr = v_valid ? ADDR_W'(v_cnt - V_ACT_START_C) : '0;

  // Colour is blanked outside the active area whatever the memory returns
  assign pixel = rgb_t'(vga_data);
  assign vga_r = valid ? pixel.r : '0;
  assign vga_g = valid ? pixel.g : '0;
  assign vga_b = valid ? pixel.b : '0;

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed bench for vga_ctrl. Horizontal timing is the real 640-wide line;
// the vertical axis is shortened to 16 lines (sync 2, active lines 5..12) so
// whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_ctrl;

  localparam int HS    = 96;
  localparam int HAS   = 144;
  localparam int HAE   = 784;
  localparam int HT    = 800;
  localparam int VS    = 2;
  localparam int VAS   = 5;
  localparam int VAE   = 13;
  localparam int VT    = 16;
  localparam int FRAME = HT * VT;

  logic        pclk  = 1'b0;
  logic        reset = 1'b1;
  logic        mem_on = 1'b0;
  logic [23:0] vga_data;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic        hsync;
  logic        vsync;
  logic        valid;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 pclk = ~pclk;

  // Model video memory: pixel word from the presented address, all ones
  // whenever the controller is blanking
  assign vga_data = (mem_on && valid) ? {h_addr[7:0], v_addr[7:0], 8'hA5} : 24'hFFFFFF;

  vga_ctrl #(
    .H_SYNC      (HS),
    .H_ACT_START (HAS),
    .H_ACT_END   (HAE),
    .H_TOTAL     (HT),
    .V_SYNC      (VS),
    .V_ACT_START (VAS),
    .V_ACT_END   (VAE),
    .V_TOTAL     (VT)
  ) dut (
    .pclk     (pclk),
    .reset    (reset),
    .vga_data (vga_data),
    .h_addr   (h_addr),
    .v_addr   (v_addr),
    .hsync    (hsync),
    .vsync    (vsync),
    .valid    (valid),
    .vga_r    (vga_r),
    .vga_g    (vga_g),
    .vga_b    (vga_b)
  );

  task automatic step();
    @(posedge pclk);
    #1;
    cyc++;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) step();
  endtask

  // Release reset at a falling edge and return the cycle of the first hsync rise
  task automatic release_and_find_rise(output int rise);
    rise = -1;
    @(negedge pclk);
    reset = 1'b1;
    cyc = 0;
    #1;
    for (int i = 0; i < 200 && rise < 0; i++) begin
      step();
      if (hsync === 1'b1) rise = cyc;
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    mem_on = 1'b0;
    #2 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge pclk);
      #1;
      if (hsync !== 1'b0 || vsync !== 1'b0 || valid !== 1'b0 || h_addr !== 10'd0 ||
          v_addr !== 10'd0 || vga_r !== 8'd0 || vga_g !== 8'd0 || vga_b !== 8'd0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_hold: %0d bad cycles, required 0", bad); end
    checks++;
    if (hsync !== 1'b0) begin errors++; $display("FAIL reset_hsync: got %b want 0", hsync); end
    checks++;
    if (vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b want 0", vsync); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++;
    if (h_addr !== 10'd0 || v_addr !== 10'd0) begin
      errors++; $display("FAIL reset_addr: got h=%0d v=%0d want 0/0", h_addr, v_addr);
    end
    checks++;
    if ({vga_r, vga_g, vga_b} !== 24'h0) begin
      errors++; $display("FAIL reset_rgb: got %h want 000000", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_first_hsync();
    int rise;
    release_and_find_rise(rise);
    checks++;
    if (rise != HS) begin errors++; $display("FAIL first_hsync_rise: got cycle %0d want %0d", rise, HS); end
  endtask

  task automatic test_line();
    int low;
    int vcount;
    int run;
    int maxrun;
    low = 0; vcount = 0; run = 0; maxrun = 0;
    run_until(HT);
    checks++;
    if (hsync !== 1'b0) begin errors++; $display("FAIL hsync_line_start: got %b want 0", hsync); end
    for (int i = 0; i < HT; i++) begin
      if (hsync === 1'b0) low++;
      if (valid === 1'b1) vcount++;
      step();
    end
    checks++;
    if (low != HS) begin errors++; $display("FAIL hsync_low_width: got %0d want %0d", low, HS); end
    checks++;
    if (vcount != 0) begin errors++; $display("FAIL blank_line_valid: got %0d want 0", vcount); end
    checks++;
    if (hsync !== 1'b0) begin errors++; $display("FAIL hsync_period: got %b at cycle %0d want 0", hsync, cyc); end

    // First active line
    run_until(VAS * HT);
    vcount = 0;
    for (int i = 0; i < HT; i++) begin
      if (valid === 1'b1) begin
        vcount++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (i == HAS - 1) begin
        checks++;
        if (valid !== 1'b0 || h_addr !== 10'd0) begin
          errors++; $display("FAIL pre_active: got valid=%b h=%0d want 0/0", valid, h_addr);
        end
      end
      if (i == HAS) begin
        checks++;
        if (valid !== 1'b1 || h_addr !== 10'd0 || v_addr !== 10'd0) begin
          errors++; $display("FAIL first_pixel: got valid=%b h=%0d v=%0d want 1/0/0", valid, h_addr, v_addr);
        end
      end
      if (i == HAS + 1) begin
        checks++;
        if (h_addr !== 10'd1) begin errors++; $display("FAIL second_pixel: got h=%0d want 1", h_addr); end
      end
      if (i == HAE - 1) begin
        checks++;
        if (valid !== 1'b1 || h_addr !== 10'd639) begin
          errors++; $display("FAIL last_pixel: got valid=%b h=%0d want 1/639", valid, h_addr);
        end
      end
      if (i == HAE) begin
        checks++;
        if (valid !== 1'b0 || h_addr !== 10'd0) begin
          errors++; $display("FAIL post_active: got valid=%b h=%0d want 0/0", valid, h_addr);
        end
      end
      step();
    end
    checks++;
    if (vcount != 640) begin errors++; $display("FAIL line_valid_count: got %0d want 640", vcount); end
    checks++;
    if (maxrun != 640) begin errors++; $display("FAIL line_valid_run: got %0d want 640", maxrun); end
  endtask

  task automatic test_frame();
    int h, v, vs_low, val_cnt;
    int hs_bad, vs_bad, val_bad, ha_bad, va_bad, col_bad;
    logic e_hs, e_vs, e_hv, e_vv, e_val;
    logic [9:0] e_ha, e_va;
    logic [23:0] e_rgb;
    vs_low = 0; val_cnt = 0;
    hs_bad = 0; vs_bad = 0; val_bad = 0; ha_bad = 0; va_bad = 0; col_bad = 0;
    mem_on = 1'b1;
    run_until(FRAME - 1);
    checks++;
    if (vsync !== 1'b1) begin errors++; $display("FAIL vsync_before_frame: got %b want 1", vsync); end
    step();
    checks++;
    if (vsync !== 1'b0) begin errors++; $display("FAIL vsync_frame_start: got %b want 0", vsync); end
    for (int i = 0; i < FRAME; i++) begin
      h = i % HT;
      v = i / HT;
      e_hs  = (h >= HS);
      e_vs  = (v >= VS);
      e_hv  = (h >= HAS) && (h < HAE);
      e_vv  = (v >= VAS) && (v < VAE);
      e_val = e_hv && e_vv;
      e_ha  = e_hv ? 10'(h - HAS) : 10'd0;
      e_va  = e_vv ? 10'(v - VAS) : 10'd0;
      e_rgb = e_val ? {e_ha[7:0], e_va[7:0], 8'hA5} : 24'h0;
      if (vsync === 1'b0) vs_low++;
      if (valid === 1'b1) val_cnt++;
      if (hsync !== e_hs) hs_bad++;
      if (vsync !== e_vs) vs_bad++;
      if (valid !== e_val) val_bad++;
      if (h_addr !== e_ha) ha_bad++;
      if (v_addr !== e_va) va_bad++;
      if ({vga_r, vga_g, vga_b} !== e_rgb) col_bad++;
      step();
    end
    checks++;
    if (vsync !== 1'b0) begin errors++; $display("FAIL frame_period: vsync %b at cycle %0d want 0", vsync, cyc); end
    checks++;
    if (vs_low != VS * HT) begin errors++; $display("FAIL vsync_low_width: got %0d want %0d", vs_low, VS * HT); end
    checks++;
    if (val_cnt != 640 * (VAE - VAS)) begin
      errors++; $display("FAIL frame_valid_count: got %0d want %0d", val_cnt, 640 * (VAE - VAS));
    end
    checks++;
    if (hs_bad != 0) begin errors++; $display("FAIL frame_hsync: got %0d bad cycles want 0", hs_bad); end
    checks++;
    if (vs_bad != 0) begin errors++; $display("FAIL frame_vsync: got %0d bad cycles want 0", vs_bad); end
    checks++;
    if (val_bad != 0) begin errors++; $display("FAIL frame_valid: got %0d bad cycles want 0", val_bad); end
    checks++;
    if (ha_bad != 0) begin errors++; $display("FAIL frame_h_addr: got %0d bad cycles want 0", ha_bad); end
    checks++;
    if (va_bad != 0) begin errors++; $display("FAIL frame_v_addr: got %0d bad cycles want 0", va_bad); end
    checks++;
    if (col_bad != 0) begin errors++; $display("FAIL frame_colour: got %0d bad cycles want 0", col_bad); end
  endtask

  task automatic test_mid_reset();
    int rise;
    run_until(2 * FRAME + 10 * HT + 400);
    checks++;
    if (valid !== 1'b1 || h_addr !== 10'd256 || v_addr !== 10'd5) begin
      errors++; $display("FAIL mid_line_position: got valid=%b h=%0d v=%0d want 1/256/5", valid, h_addr, v_addr);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (hsync !== 1'b0 || vsync !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL async_reset_sync: got hs=%b vs=%b valid=%b want 0/0/0", hsync, vsync, valid);
    end
    checks++;
    if (h_addr !== 10'd0 || v_addr !== 10'd0) begin
      errors++; $display("FAIL async_reset_addr: got h=%0d v=%0d want 0/0", h_addr, v_addr);
    end
    checks++;
    if ({vga_r, vga_g, vga_b} !== 24'h0) begin
      errors++; $display("FAIL async_reset_rgb: got %h want 000000", {vga_r, vga_g, vga_b});
    end
    repeat (3) @(posedge pclk);
    release_and_find_rise(rise);
    checks++;
    if (rise != HS) begin errors++; $display("FAIL restart_hsync_rise: got cycle %0d want %0d", rise, HS); end
    run_until(VS * HT - 1);
    checks++;
    if (vsync !== 1'b0) begin errors++; $display("FAIL restart_vsync_low: got %b want 0", vsync); end
    step();
    checks++;
    if (vsync !== 1'b1) begin errors++; $display("FAIL restart_vsync_rise: got %b want 1", vsync); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_hsync();
    test_line();
    test_frame();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
